// File: rtl/sio_rx_deframe.sv
`default_nettype none
// ============================================================================
// Module      : sio_rx_deframe
// Description : Remote IO receive deframer. Collects the recovered bit-pair
//               stream (two bits per clock, i[1] first) into one fixed-length
//               frame of NBA address bits, NBD data bits and 8 CRC bits, all
//               MSB first. It then presents address/data with a one-cycle
//               valid pulse.
//
//               Optional feature macro SIO_RX_CRC_EN:
//                 defined   - CRC-8 (poly 0x07, init 0, no reflection, no
//                             final XOR) is computed over address and data.
//                             e flags a mismatch against the received CRC.
//                 undefined - no CRC logic and e is tied to 0. The 8 CRC
//                             bits are still received and discarded, so the
//                             v timing is unchanged.
//
// Ports       : c    - clock (all logic on posedge)
//               r    - synchronous active-high reset
//               i    - recovered bit pair, i[1] older
//               s    - start strobe, marks the cycle carrying pair 0
//               a    - received address (held until next v)
//               d    - received data    (held until next v)
//               v    - one-cycle pulse, a/d/e updated this cycle
//               e    - CRC error flag for the frame reported by v
//               busy - high while a frame is being received
//
// Revision    : 1.0 - initial release
// ============================================================================
module sio_rx_deframe #(
  parameter int NBA = 8,
  parameter int NBD = 32
) (
  input  logic           c,
  input  logic           r,
  input  logic [1:0]     i,
  input  logic           s,
  output logic [NBA-1:0] a,
  output logic [NBD-1:0] d,
  output logic           v,
  output logic           e,
  output logic           busy
);

  localparam int c_NDB = NBA + NBD;      // address + data bits
  localparam int c_NF  = c_NDB + 8;      // full frame bits
  localparam int c_NP  = c_NF / 2;       // pair-cycles per frame
  localparam int c_CW  = $clog2(c_NP);

  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NP - 1);
  localparam logic [c_CW-1:0] c_NDP  = c_CW'(c_NDB / 2);  // first CRC pair index
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RECV = 1'b1;

  logic [0:0]       r_state;
  logic [c_CW-1:0]  r_cnt;
  logic [c_NDB-1:0] r_sh;
  logic [NBA-1:0]   r_a;
  logic [NBD-1:0]   r_d;
  logic             r_v;

  // Last pair of the frame is on i this cycle. A new s here aborts instead.
  logic w_fin;
  // Current RECV pair still belongs to the address/data field.
  logic w_data;

  assign w_fin  = (r_state == c_RECV) && !s && (r_cnt == c_LAST);
  assign w_data = (r_cnt < c_NDP);

`ifdef SIO_RX_CRC_EN
  logic [7:0] r_crc;
  logic [5:0] r_rc;    // first three received CRC pairs
  logic       r_e;
  logic [7:0] w_rx_crc;

  // Two serial CRC-8 steps, older bit (p[1]) first.
  function automatic logic [7:0] crc_pair(input logic [7:0] cin,
                                          input logic [1:0] p);
    logic [7:0] t;
    t = cin;
    for (int k = 1; k >= 0; k--) begin
      t = {t[6:0], 1'b0} ^ ((t[7] ^ p[k]) ? 8'h07 : 8'h00);
    end
    return t;
  endfunction

  // The final CRC pair is never registered. It is compared straight from i.
  assign w_rx_crc = {r_rc, i};
  assign e        = r_e;
`else
  assign e = 1'b0;
`endif

  always_ff @(posedge c) begin
    if (r) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_v     <= 1'b0;
`ifdef SIO_RX_CRC_EN
      r_crc   <= 8'h00;
      r_rc    <= 6'd0;
      r_e     <= 1'b0;
`endif
    end else begin
      r_v <= 1'b0;
      if (s) begin
        // Start, or restart over an in-flight frame. Pair 0 is on i now.
        r_state <= c_RECV;
        r_cnt   <= c_ONE;
        r_sh    <= {r_sh[c_NDB-3:0], i};
`ifdef SIO_RX_CRC_EN
        r_crc   <= crc_pair(8'h00, i);
`endif
      end else if (r_state == c_RECV) begin
        r_cnt <= r_cnt + c_ONE;
        if (w_data) begin
          // Stale bits from an earlier frame are shifted out by the time
          // the address/data field is complete.
          r_sh <= {r_sh[c_NDB-3:0], i};
`ifdef SIO_RX_CRC_EN
          r_crc <= crc_pair(r_crc, i);
        end else begin
          r_rc <= {r_rc[3:0], i};
`endif
        end
        if (w_fin) begin
          r_state <= c_IDLE;
          r_v     <= 1'b1;
          r_a     <= r_sh[c_NDB-1:NBD];
          r_d     <= r_sh[NBD-1:0];
`ifdef SIO_RX_CRC_EN
          r_e     <= (w_rx_crc != r_crc);
`endif
        end
      end
    end
  end

  assign a    = r_a;
  assign d    = r_d;
  assign v    = r_v;
  assign busy = (r_state == c_RECV);

endmodule
`default_nettype wire
